// File: rtl/calc1_pkg.sv
// -----------------------------------------------------------------------------
// calc1_pkg
// Shared definitions for the four-port 32-bit calculator:
//   - operand/result width and port count
//   - command codes, response codes, per-port FSM state codes
//   - result_t (response code + data) and calc_op(), the combinational ALU
//     that turns a latched command and its two operands into a response.
// All vectors follow the block's big-endian convention (bit 0 = MSB).
// -----------------------------------------------------------------------------
package calc1_pkg;

   localparam int DW    = 32;
   localparam int NPORT = 4;

   typedef logic [0:3]    cmd_t;
   typedef logic [0:1]    resp_t;
   typedef logic [0:DW-1] data_t;

   localparam cmd_t CMD_NOP = 4'd0;
   localparam cmd_t CMD_ADD = 4'd1;
   localparam cmd_t CMD_SUB = 4'd2;
   localparam cmd_t CMD_SHL = 4'd5;
   localparam cmd_t CMD_SHR = 4'd6;

   localparam resp_t RESP_NONE = 2'd0;
   localparam resp_t RESP_OK   = 2'd1;
   localparam resp_t RESP_ERR  = 2'd2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OP2  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef struct packed {
      resp_t resp;
      data_t data;
   } result_t;

   // Error is the fall-through answer: invalid commands, add carry-out and
   // subtract underflow all report RESP_ERR with zero data.
   function automatic result_t calc_op(input cmd_t cmd, input data_t op1, input data_t op2);
      logic [DW:0] sum;
      result_t     r;
      // NOTE: every output gets a value before the case, so no path can leave
      // it unassigned; the same habit keeps always_comb blocks latch-free.
      r.resp = RESP_ERR;
      r.data = '0;
      sum    = {1'b0, op1} + {1'b0, op2};
      case (cmd)
         CMD_ADD: begin
            if (!sum[DW]) begin
               r.resp = RESP_OK;
               r.data = sum[DW-1:0];
            end
         end
         CMD_SUB: begin
            if (op2 <= op1) begin
               r.resp = RESP_OK;
               r.data = op1 - op2;
            end
         end
         // Shift amount is the low five bits of operand2 (bits 27..31 big-endian).
         CMD_SHL: begin
            r.resp = RESP_OK;
            r.data = op1 << op2[DW-5:DW-1];
         end
         CMD_SHR: begin
            r.resp = RESP_OK;
            r.data = op1 >> op2[DW-5:DW-1];
         end
         default: ;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/calc1_if.sv
// -----------------------------------------------------------------------------
// calc1_if
// One requester channel of the calculator.
//   cmd_in   [0:3]  command, sampled in the first cycle of a request
//   data_in  [0:31] operand1 in the first cycle, operand2 in the second
//   out_data [0:31] result, meaningful only while out_resp != 0
//   out_resp [0:1]  0 none, 1 success, 2 error
// Modports: master = requester side, slave = calculator side.
// -----------------------------------------------------------------------------
interface calc1_if;
   import calc1_pkg::*;

   cmd_t  cmd_in;
   data_t data_in;
   data_t out_data;
   resp_t out_resp;

   modport master (
      output cmd_in,
      output data_in,
      input  out_data,
      input  out_resp
   );

   modport slave (
      input  cmd_in,
      input  data_in,
      output out_data,
      output out_resp
   );

endinterface

// File: rtl/calc1_port.sv
// -----------------------------------------------------------------------------
// calc1_port
// One independent calculator channel: IDLE -> OP2 -> RESP -> IDLE.
//   clk  in  rising-edge clock
//   rst  in  asynchronous, active-high reset
//   req  calc1_if.slave channel
// A nonzero command in IDLE latches command and operand1; the next edge
// latches operand2; the edge after that loads the registered response, which
// is held for exactly one cycle before the outputs return to zero.
// -----------------------------------------------------------------------------
module calc1_port
   import calc1_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   calc1_if.slave req
);

   logic [1:0] state;
   cmd_t       cmd_q;
   data_t      op1_q;
   data_t      op2_q;
   resp_t      out_resp_q;
   data_t      out_data_q;
   result_t    res;

   // ALU sees only latched values, so mid-request input activity is ignored.
   assign res = calc_op(cmd_q, op1_q, op2_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         cmd_q      <= CMD_NOP;
         op1_q      <= '0;
         op2_q      <= '0;
         out_resp_q <= RESP_NONE;
         out_data_q <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here
         // samples the pre-edge values regardless of statement order.
         out_resp_q <= RESP_NONE;
         out_data_q <= '0;
         case (state)
            ST_IDLE: begin
               if (req.cmd_in != CMD_NOP) begin
                  cmd_q <= req.cmd_in;
                  op1_q <= req.data_in;
                  state <= ST_OP2;
               end
            end
            // Command input is deliberately not looked at here.
            ST_OP2: begin
               op2_q <= req.data_in;
               state <= ST_RESP;
            end
            ST_RESP: begin
               out_resp_q <= res.resp;
               out_data_q <= res.data;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign req.out_resp = out_resp_q;
   assign req.out_data = out_data_q;

endmodule

// File: rtl/calc1_top.sv
// -----------------------------------------------------------------------------
// calc1_top
// Four-port 32-bit integer calculator; each port is a fully independent
// calc1_port channel sharing clock and reset.
//   c_clk      in   clock, rising edge
//   reset      in   [1:7] asynchronous, active-high; any set bit resets
//   req1..req4 calc1_if.slave request/response channels
// -----------------------------------------------------------------------------
module calc1_top
   import calc1_pkg::*;
(
   input  logic       c_clk,
   input  logic [1:7] reset,
   calc1_if.slave     req1,
   calc1_if.slave     req2,
   calc1_if.slave     req3,
   calc1_if.slave     req4
);

   logic rst;

   assign rst = |reset;

   calc1_port u_port1 (.clk(c_clk), .rst(rst), .req(req1));
   calc1_port u_port2 (.clk(c_clk), .rst(rst), .req(req2));
   calc1_port u_port3 (.clk(c_clk), .rst(rst), .req(req3));
   calc1_port u_port4 (.clk(c_clk), .rst(rst), .req(req4));

endmodule

// File: tb/tb_calc1_top.sv
// -----------------------------------------------------------------------------
// tb_calc1_top
// Self-checking bench for calc1_top: directed cases, an add sweep, randomized
// multi-port traffic against a plain-arithmetic reference model, and reset
// behaviour (reset[1] held, then each of reset[2..7] aborting a request).
// -----------------------------------------------------------------------------
module tb_calc1_top;
   import calc1_pkg::*;

   logic       c_clk = 1'b0;
   logic [1:7] reset = '0;

   calc1_if p1 ();
   calc1_if p2 ();
   calc1_if p3 ();
   calc1_if p4 ();

   logic [3:0]  cmd  [NPORT];
   logic [31:0] din  [NPORT];
   logic [1:0]  resp [NPORT];
   logic [31:0] dout [NPORT];

   assign p1.cmd_in  = cmd[0];
   assign p2.cmd_in  = cmd[1];
   assign p3.cmd_in  = cmd[2];
   assign p4.cmd_in  = cmd[3];
   assign p1.data_in = din[0];
   assign p2.data_in = din[1];
   assign p3.data_in = din[2];
   assign p4.data_in = din[3];
   assign resp[0] = p1.out_resp;
   assign resp[1] = p2.out_resp;
   assign resp[2] = p3.out_resp;
   assign resp[3] = p4.out_resp;
   assign dout[0] = p1.out_data;
   assign dout[1] = p2.out_data;
   assign dout[2] = p3.out_data;
   assign dout[3] = p4.out_data;

   calc1_top dut (
      .c_clk (c_clk),
      .reset (reset),
      .req1  (p1),
      .req2  (p2),
      .req3  (p3),
      .req4  (p4)
   );

   always #5 c_clk = ~c_clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Per-port transaction setup and captured response ({resp, data}).
   logic [3:0]  t_cmd [NPORT];
   logic [31:0] t_op1 [NPORT];
   logic [31:0] t_op2 [NPORT];
   logic [33:0] got   [NPORT];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      else
         n_pass++;
   endtask

   // Reference model: response code and data straight from the arithmetic rules.
   function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      longint      s;
      logic [31:0] r;
      case (c)
         4'd1: begin
            s = longint'(a) + longint'(b);
            if (s > 64'hFFFF_FFFF) return {2'd2, 32'd0};
            r = s[31:0];
            return {2'd1, r};
         end
         4'd2: begin
            s = longint'(a) - longint'(b);
            if (s < 0) return {2'd2, 32'd0};
            r = s[31:0];
            return {2'd1, r};
         end
         4'd5: begin
            r = a << (b % 32);
            return {2'd1, r};
         end
         4'd6: begin
            r = a >> (b % 32);
            return {2'd1, r};
         end
         default: return {2'd2, 32'd0};
      endcase
   endfunction

   task automatic check_idle(input string tag);
      for (int i = 0; i < NPORT; i++)
         check($sformatf("%s_p%0d", tag, i + 1), {resp[i], dout[i]}, 64'd0);
   endtask

   // One request on every port in mask. Inputs change on the falling edge;
   // outputs are sampled on the falling edge. With hold_cmd the command stays
   // on the bus through both request cycles, otherwise junk commands are
   // driven during OP2 and RESP, which the design must ignore.
   task automatic run_txn(input logic [3:0] mask, input bit hold_cmd);
      @(negedge c_clk);
      for (int i = 0; i < NPORT; i++)
         if (mask[i]) begin
            cmd[i] = t_cmd[i];
            din[i] = t_op1[i];
         end
      @(negedge c_clk);
      check_idle("early_op2");
      for (int i = 0; i < NPORT; i++)
         if (mask[i]) begin
            din[i] = t_op2[i];
            if (!hold_cmd) cmd[i] = 4'($urandom_range(0, 15));
         end
      @(negedge c_clk);
      check_idle("early_resp");
      for (int i = 0; i < NPORT; i++) begin
         cmd[i] = (mask[i] && !hold_cmd) ? 4'($urandom_range(1, 15)) : 4'd0;
         din[i] = $urandom;
      end
      @(negedge c_clk);
      for (int i = 0; i < NPORT; i++) begin
         got[i] = {resp[i], dout[i]};
         if (mask[i])
            check($sformatf("resp_p%0d_cmd%0d", i + 1, t_cmd[i]), got[i],
                  model(t_cmd[i], t_op1[i], t_op2[i]));
         else
            check($sformatf("quiet_p%0d", i + 1), got[i], 64'd0);
         cmd[i] = 4'd0;
      end
      @(negedge c_clk);
      check_idle("one_cycle");
   endtask

   task automatic txn1(input int p, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input bit hold_cmd);
      t_cmd[p] = c;
      t_op1[p] = a;
      t_op2[p] = b;
      run_txn(4'b0001 << p, hold_cmd);
   endtask

   // Start a request on all ports, assert one reset bit across the operand2
   // edge, then confirm no response ever appears.
   task automatic reset_abort(input int k);
      @(negedge c_clk);
      for (int i = 0; i < NPORT; i++) begin
         cmd[i] = 4'd1;
         din[i] = $urandom;
      end
      @(negedge c_clk);
      for (int i = 0; i < NPORT; i++) begin
         cmd[i] = 4'd0;
         din[i] = $urandom;
      end
      reset[k] = 1'b1;
      @(negedge c_clk);
      reset[k] = 1'b0;
      repeat (3) begin
         @(negedge c_clk);
         check_idle($sformatf("rst%0d_abort", k));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NPORT; i++) begin
         cmd[i] = 4'd0;
         din[i] = 32'd0;
      end

      // reset[1] held for four cycles
      #2 reset[1] = 1'b1;
      repeat (4) begin
         @(negedge c_clk);
         check_idle("reset1");
      end
      reset[1] = 1'b0;
      @(negedge c_clk);
      check_idle("after_reset");

      // Directed adds on port 1
      txn1(0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 1'b0);
      check("add_small", got[0], {2'd1, 32'h2000_0000});
      txn1(0, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 1'b0);
      check("add_big", got[0], {2'd1, 32'h3FFF_FFFE});
      txn1(0, 4'd1, 32'd0, 32'd0, 1'b0);
      check("add_zero", got[0], {2'd1, 32'd0});
      txn1(0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      check("add_carry", got[0], {2'd2, 32'd0});

      // Subtract underflow and normal
      txn1(0, 4'd2, 32'd1, 32'd15, 1'b0);
      check("sub_under", got[0], {2'd2, 32'd0});
      txn1(0, 4'd2, 32'd15, 32'd1, 1'b0);
      check("sub_ok", got[0], {2'd1, 32'd14});

      // Invalid commands held through both request cycles
      txn1(0, 4'd3, $urandom, $urandom, 1'b1);
      check("inv_cmd3", got[0], {2'd2, 32'd0});
      txn1(0, 4'd4, $urandom, $urandom, 1'b1);
      check("inv_cmd4", got[0], {2'd2, 32'd0});
      repeat (3) begin
         @(negedge c_clk);
         check_idle("inv_no_extra");
      end

      // Shifts, including an amount with upper bits set
      txn1(0, 4'd5, 32'h0000_0001, 32'd31, 1'b0);
      check("shl_31", got[0], {2'd1, 32'h8000_0000});
      txn1(0, 4'd6, 32'h8000_0000, 32'h0000_0021, 1'b0);
      check("shr_wrap", got[0], {2'd1, 32'h4000_0000});

      // All four ports in the same cycle, different commands
      t_cmd[0] = 4'd1; t_op1[0] = 32'd10;         t_op2[0] = 32'd20;
      t_cmd[1] = 4'd2; t_op1[1] = 32'd100;        t_op2[1] = 32'd1;
      t_cmd[2] = 4'd5; t_op1[2] = 32'h0000_0003;  t_op2[2] = 32'd4;
      t_cmd[3] = 4'd6; t_op1[3] = 32'h0000_00F0;  t_op2[3] = 32'd4;
      run_txn(4'hF, 1'b0);
      check("all_p1", got[0], {2'd1, 32'd30});
      check("all_p2", got[1], {2'd1, 32'd99});
      check("all_p3", got[2], {2'd1, 32'h30});
      check("all_p4", got[3], {2'd1, 32'h0F});

      // Each remaining reset bit aborts an in-flight request
      for (int k = 2; k <= 7; k++) reset_abort(k);

      // Add sweep, rotating across ports
      for (int x = 0; x < 15; x++)
         for (int y = 0; y < 15; y++) begin
            txn1((x + y) % NPORT, 4'd1, 32'(x), 32'(y), 1'b0);
            check("sweep", got[(x + y) % NPORT], {2'd1, 32'(x + y)});
         end

      // Randomized multi-port traffic
      for (int n = 0; n < 150; n++) begin
         for (int i = 0; i < NPORT; i++) begin
            case ($urandom_range(0, 4))
               0: t_cmd[i] = 4'd1;
               1: t_cmd[i] = 4'd2;
               2: t_cmd[i] = 4'd5;
               3: t_cmd[i] = 4'd6;
               default: t_cmd[i] = 4'($urandom_range(1, 15));
            endcase
            if ($urandom_range(0, 1) == 0) begin
               t_op1[i] = $urandom_range(0, 1000);
               t_op2[i] = $urandom_range(0, 1000);
            end else begin
               t_op1[i] = $urandom;
               t_op2[i] = $urandom;
            end
         end
         run_txn(4'($urandom_range(1, 15)), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
